// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers for the AES MixColumns pipeline: reduction polynomial, xtime,
// column byte ordering and mode encoding.
package aes_gf_pkg;

  localparam logic [7:0]  GF_POLY    = 8'h1b;
  localparam int unsigned COL_W      = 32;
  localparam int unsigned COL_BYTES  = 4;
  localparam int unsigned BYTE_W     = 8;
  // Byte b0 sits in the top byte of each column; b3 in the bottom byte.
  localparam int unsigned COL_B0_LSB = 24;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } gf_mode_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic int unsigned col_byte_lsb(input int unsigned idx);
    return COL_B0_LSB - BYTE_W * idx;
  endfunction

endpackage

// File: rtl/gf_col_combine.sv
// Combines one column's precomputed byte multiples into its MixColumns result.
// Inverse path is present only when GF_MIXCOL_INV_EN is defined.
module gf_col_combine
  import aes_gf_pkg::*;
(
  input  logic [COL_W-1:0] b_i,
  input  logic [COL_W-1:0] b2_i,
`ifdef GF_MIXCOL_INV_EN
  input  logic [COL_W-1:0] b4_i,
  input  logic [COL_W-1:0] b8_i,
  input  logic             inv_i,
`endif
  output logic [COL_W-1:0] res_o
);

  logic [7:0] b  [COL_BYTES];
  logic [7:0] b2 [COL_BYTES];
`ifdef GF_MIXCOL_INV_EN
  logic [7:0] b4 [COL_BYTES];
  logic [7:0] b8 [COL_BYTES];
`endif

  for (genvar i = 0; i < COL_BYTES; i++) begin : g_byte
    localparam int unsigned I1 = (i + 1) % COL_BYTES;
    localparam int unsigned I2 = (i + 2) % COL_BYTES;
    localparam int unsigned I3 = (i + 3) % COL_BYTES;

    logic [7:0] fwd;

    assign b[i]  = b_i[col_byte_lsb(i) +: 8];
    assign b2[i] = b2_i[col_byte_lsb(i) +: 8];

    // 2*b_i ^ 3*b_(i+1) ^ b_(i+2) ^ b_(i+3)
    assign fwd = b2[i] ^ b2[I1] ^ b[I1] ^ b[I2] ^ b[I3];

`ifdef GF_MIXCOL_INV_EN
    logic [7:0] inv;

    assign b4[i] = b4_i[col_byte_lsb(i) +: 8];
    assign b8[i] = b8_i[col_byte_lsb(i) +: 8];

    // 14 = 8^4^2, 11 = 8^2^1, 13 = 8^4^1, 9 = 8^1
    assign inv = (b8[i] ^ b4[i] ^ b2[i]) ^ (b8[I1] ^ b2[I1] ^ b[I1]) ^
                 (b8[I2] ^ b4[I2] ^ b[I2]) ^ (b8[I3] ^ b[I3]);

    assign res_o[col_byte_lsb(i) +: 8] = (inv_i == MODE_INV) ? inv : fwd;
`else
    assign res_o[col_byte_lsb(i) +: 8] = fwd;
`endif
  end

endmodule

// File: rtl/gf_mixcol_pipe.sv
// Two-stage valid/ready AES (Inv)MixColumns pipeline over NCOL columns per beat.
// Define GF_MIXCOL_INV_EN to add the inverse transform; otherwise every beat is forward.
module gf_mixcol_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned NCOL = 4,
  parameter int unsigned DW   = 32 * NCOL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int unsigned NBYTES = DW / BYTE_W;

  logic adv1, adv2, accept;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_b_q, s1_b_d;
  logic [DW-1:0] s1_b2_q, s1_b2_d;
  logic [DW-1:0] in_b2;

  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [DW-1:0] comb_res;

`ifdef GF_MIXCOL_INV_EN
  logic          s1_inv_q, s1_inv_d;
  logic [DW-1:0] s1_b4_q, s1_b4_d;
  logic [DW-1:0] s1_b8_q, s1_b8_d;
  logic [DW-1:0] in_b4, in_b8;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !rst;
  assign accept   = in_valid && in_ready;

  // xtime acts per byte, so byte order within a column does not matter here.
  for (genvar i = 0; i < NBYTES; i++) begin : g_xt
    assign in_b2[BYTE_W*i +: BYTE_W] = xtime(in_data[BYTE_W*i +: BYTE_W]);
`ifdef GF_MIXCOL_INV_EN
    assign in_b4[BYTE_W*i +: BYTE_W] = xtime(in_b2[BYTE_W*i +: BYTE_W]);
    assign in_b8[BYTE_W*i +: BYTE_W] = xtime(in_b4[BYTE_W*i +: BYTE_W]);
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_b_d     = s1_b_q;
    s1_b2_d    = s1_b2_q;
`ifdef GF_MIXCOL_INV_EN
    s1_inv_d   = s1_inv_q;
    s1_b4_d    = s1_b4_q;
    s1_b8_d    = s1_b8_q;
`endif
    if (adv1) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_b_d  = in_data;
      s1_b2_d = in_b2;
`ifdef GF_MIXCOL_INV_EN
      s1_inv_d = in_inv;
      s1_b4_d  = in_b4;
      s1_b8_d  = in_b8;
`endif
    end
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    gf_col_combine u_combine (
      .b_i   (s1_b_q[COL_W*c +: COL_W]),
      .b2_i  (s1_b2_q[COL_W*c +: COL_W]),
`ifdef GF_MIXCOL_INV_EN
      .b4_i  (s1_b4_q[COL_W*c +: COL_W]),
      .b8_i  (s1_b8_q[COL_W*c +: COL_W]),
      .inv_i (s1_inv_q),
`endif
      .res_o (comb_res[COL_W*c +: COL_W])
    );
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = comb_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_b_q     <= '0;
      s1_b2_q    <= '0;
`ifdef GF_MIXCOL_INV_EN
      s1_inv_q   <= MODE_FWD;
      s1_b4_q    <= '0;
      s1_b8_q    <= '0;
`endif
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_b_q     <= s1_b_d;
      s1_b2_q    <= s1_b2_d;
`ifdef GF_MIXCOL_INV_EN
      s1_inv_q   <= s1_inv_d;
      s1_b4_q    <= s1_b4_d;
      s1_b8_q    <= s1_b8_d;
`endif
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

endmodule

// File: tb/tb_gf_mixcol_pipe.sv
// Self-checking bench for gf_mixcol_pipe (NCOL = 4) against a GF(2^8) matrix model.
module tb_gf_mixcol_pipe;

  localparam int unsigned NCOL = 4;
  localparam int unsigned DW   = 32 * NCOL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  gf_mixcol_pipe #(.NCOL(NCOL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  logic [DW-1:0] exp_q[$];
  logic acc, cons;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [DW-1:0] ref_mix(input logic [DW-1:0] d, input logic inv);
    logic [7:0]    coef [4];
    logic [7:0]    b    [4];
    logic [7:0]    r;
    logic [31:0]   col;
    logic [DW-1:0] res;
    logic          use_inv;
`ifdef GF_MIXCOL_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    if (use_inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < NCOL; c++) begin
      col = d[32*c +: 32];
      for (int k = 0; k < 4; k++) b[k] = col[31-8*k -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(coef[j], b[(i+j)%4]);
        res[32*c + 31 - 8*i -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive at negedge, evaluate handshake just after, score the output.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic inv,
                      input logic ordy, output logic a, output logic c);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    out_ready = ordy;
    #1;
    cyc++;
    a = v && in_ready;
    c = out_valid && out_ready;
    if (exp_q.size() == 0) begin
      check_eq("spurious_out", out_valid, 1'b0);
    end else if (out_valid) begin
      check_eq("out_data", out_data, exp_q[0]);
      if (c) void'(exp_q.pop_front());
    end
    if (a) exp_q.push_back(ref_mix(d, inv));
  endtask

  task automatic directed(input string tag, input logic [DW-1:0] d, input logic inv,
                          input logic [DW-1:0] exp);
    int   t0;
    logic found;
    step(1'b1, d, inv, 1'b1, acc, cons);
    t0 = cyc;
    check_eq({tag, "_accept"}, acc, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, rand_data(), 1'b0, 1'b1, acc, cons);
      if (cons) begin
        found = 1'b1;
        check_eq({tag, "_latency"}, cyc - t0, 2);
        check_eq({tag, "_value"}, out_data, exp);
      end
    end
    check_eq({tag, "_seen"}, found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc, last_cons, n_cons, n_acc;
    logic [DW-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Known AES vectors in columns 0/1; columns 2/3 are fixed points of both transforms.
    directed("fwd_vec", {32'hc6c6c6c6, 32'h01010101, 32'hd4bf5d30, 32'hdb135345}, 1'b0,
             {32'hc6c6c6c6, 32'h01010101, 32'h046681e5, 32'h8e4da1bc});
`ifdef GF_MIXCOL_INV_EN
    directed("inv_vec", {32'hc6c6c6c6, 32'h01010101, 32'h046681e5, 32'h8e4da1bc}, 1'b1,
             {32'hc6c6c6c6, 32'h01010101, 32'hd4bf5d30, 32'hdb135345});
`else
    directed("inv_ignored", {32'hc6c6c6c6, 32'h01010101, 32'hd4bf5d30, 32'hdb135345}, 1'b1,
             {32'hc6c6c6c6, 32'h01010101, 32'h046681e5, 32'h8e4da1bc});
`endif

    // Back-to-back, alternating modes.
    first_acc = -1; last_cons = -1; n_cons = 0;
    for (int j = 0; j < 12; j++) begin
      d = {32'hc6c6c6c6, 32'h01010101, $urandom, $urandom};
      step(j < 8, d, j[0], 1'b1, acc, cons);
      if (j < 8) check_eq("tp_accept", acc, 1'b1);
      if (acc && first_acc < 0) first_acc = cyc;
      if (cons) begin
        n_cons++;
        last_cons = cyc;
        check_eq("tp_fixed_cols", out_data[127:64], {32'hc6c6c6c6, 32'h01010101});
      end
    end
    check_eq("tp_count", n_cons, 8);
    check_eq("tp_span", last_cons - first_acc, 9);

    // Backpressure: only two beats fit.
    n_acc = 0;
    for (int j = 0; j < 5; j++) begin
      step(1'b1, rand_data(), $urandom_range(0, 1), 1'b0, acc, cons);
      n_acc += int'(acc);
      if (j >= 2) check_eq("bp_in_ready", in_ready, 1'b0);
    end
    check_eq("bp_accepted", n_acc, 2);
    n_cons = 0;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, rand_data(), 1'b0, 1'b1, acc, cons);
      n_cons += int'(cons);
    end
    check_eq("bp_drained", n_cons, 2);

    // Random traffic with random backpressure.
    for (int j = 0; j < 400; j++) begin
      step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, acc, cons);
    end
    for (int j = 0; j < 20 && exp_q.size() != 0; j++) begin
      step(1'b0, rand_data(), 1'b0, 1'b1, acc, cons);
    end
    check_eq("rand_drain_empty", exp_q.size(), 0);

    // Reset with two beats in flight.
    step(1'b1, rand_data(), 1'b0, 1'b0, acc, cons);
    step(1'b1, rand_data(), 1'b1, 1'b0, acc, cons);
    check_eq("mid_rst_inflight", exp_q.size(), 2);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = rand_data(); out_ready = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_out_data", out_data, '0);
    exp_q.delete();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("mid_rst_release_ready", in_ready, 1'b1);
    n_cons = 0;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, rand_data(), 1'b0, 1'b1, acc, cons);
      n_cons += int'(out_valid);
    end
    check_eq("mid_rst_no_stale", n_cons, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
